// File: rtl/nios_dbg_cmd_sysclk_bridge.sv
// Nios II debug slave, system-clock side: syncs UIR/UDR strobes from TCK,
// latches IR, queues DR updates in a FWFT FIFO drained by valid/ready.
//
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   ir_in, sr           quasi-static IR / DR shift register from TCK side
//   vs_uir, vs_udr      TCK-domain update strobes (async to clk)
//   cmd_ready           consumer accepts head command
//   ovf_clr             clears sticky overflow (set wins)
//   cmd_valid           FIFO non-empty
//   cmd_ir, cmd_data    head command (valid only with cmd_valid)
//   ir_update           one-cycle pulse per synchronised UIR rise
//   cur_ir              last IR latched on UIR
//   fifo_level          occupied entries
//   overflow            sticky: a UDR command was dropped

`timescale 1ns/1ps

module nios_dbg_cmd_sysclk_bridge #(
   parameter int DR_W        = 38,
   parameter int IR_W        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int LW = $clog2(FIFO_DEPTH + 1),
   localparam int EW = IR_W + DR_W
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [IR_W-1:0] ir_in,
   input  logic [DR_W-1:0] sr,
   input  logic            vs_uir,
   input  logic            vs_udr,
   input  logic            cmd_ready,
   input  logic            ovf_clr,
   output logic            cmd_valid,
   output logic [IR_W-1:0] cmd_ir,
   output logic [DR_W-1:0] cmd_data,
   output logic            ir_update,
   output logic [IR_W-1:0] cur_ir,
   output logic [LW-1:0]   fifo_level,
   output logic            overflow
);

   // Synchroniser chains; the top bit is the synchronised strobe.
   logic [SYNC_STAGES-1:0] uir_sync_q;
   logic [SYNC_STAGES-1:0] udr_sync_q;
   logic                   uir_prev_q;
   logic                   udr_prev_q;

   logic                   uir_rise;
   logic                   udr_rise;

   logic                   ir_update_q;
   logic [IR_W-1:0]        cur_ir_q;

   logic [AW-1:0]          wptr_q, wptr_d;
   logic [AW-1:0]          rptr_q, rptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;

   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [EW-1:0]          entry;
   logic [EW-1:0]          head;

   logic                   full;
   logic                   pop;
   logic                   push_ok;
   logic                   push_rej;

   assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
   assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;

   // A UIR rise in the same cycle supplies the IR directly, since cur_ir
   // only picks it up at the coming edge.
   assign entry = {(uir_rise ? ir_in : cur_ir_q), sr};

   assign full     = (level_q == LW'(FIFO_DEPTH));
   assign pop      = valid_q & cmd_ready;
   assign push_ok  = udr_rise & (~full | pop);
   assign push_rej = udr_rise & full & ~pop;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop)     rptr_d = rptr_q + AW'(1);
      unique case ({push_ok, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      valid_d = (level_d != '0);
      ovf_d   = push_rej | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         uir_sync_q  <= '0;
         udr_sync_q  <= '0;
         uir_prev_q  <= 1'b0;
         udr_prev_q  <= 1'b0;
         ir_update_q <= 1'b0;
         cur_ir_q    <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
         udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
         // Registered copy of next cycle's UIR rise, taken one stage early
         // so the pulse lines up with uir_rise without a gate on the output.
         ir_update_q <= uir_sync_q[SYNC_STAGES-2]
                      & ~uir_sync_q[SYNC_STAGES-1];
         if (uir_rise) cur_ir_q <= ir_in;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage has no reset; contents are qualified by cmd_valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= entry;
   end

   assign head       = mem_q[rptr_q];
   assign cmd_ir     = head[EW-1:DR_W];
   assign cmd_data   = head[DR_W-1:0];
   assign cmd_valid  = valid_q;
   assign ir_update  = ir_update_q;
   assign cur_ir     = cur_ir_q;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_nios_dbg_cmd_sysclk_bridge.sv
// Bench for nios_dbg_cmd_sysclk_bridge: directed plus random strobes,
// sample-history reference model and head-of-queue scoreboard.

`timescale 1ns/1ps

module tb_nios_dbg_cmd_sysclk_bridge;

   localparam int DR_W = 38;
   localparam int IR_W = 2;
   localparam int DEPTH = 4;
   localparam int LW = 3;
   localparam int EW = IR_W + DR_W;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [IR_W-1:0] ir_in = '0;
   logic [DR_W-1:0] sr = '0;
   logic            vs_uir = 1'b0;
   logic            vs_udr = 1'b0;
   logic            cmd_ready = 1'b0;
   logic            ovf_clr = 1'b0;
   logic            cmd_valid;
   logic [IR_W-1:0] cmd_ir;
   logic [DR_W-1:0] cmd_data;
   logic            ir_update;
   logic [IR_W-1:0] cur_ir;
   logic [LW-1:0]   fifo_level;
   logic            overflow;

   nios_dbg_cmd_sysclk_bridge #(
      .DR_W(DR_W), .IR_W(IR_W), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
      .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready),
      .ovf_clr(ovf_clr), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir),
      .cmd_data(cmd_data), .ir_update(ir_update), .cur_ir(cur_ir),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model. A strobe seen high at edge k after being low at
   // edge k-1 takes effect (push / cur_ir) at edge k+2; ir_update is
   // visible in the cycle before that edge.
   logic [EW-1:0]   m_q[$];
   logic [EW-1:0]   sb_q[$];
   logic [IR_W-1:0] m_cur_ir;
   logic            m_ovf;
   logic            m_irupd;
   bit              u_h[4];
   bit              d_h[4];
   logic            u_rise, d_rise, m_pop, m_acc, m_rej;
   logic [EW-1:0]   m_entry;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         sb_q.delete();
         m_cur_ir = '0;
         m_ovf = 1'b0;
         m_irupd = 1'b0;
         for (int i = 0; i < 4; i++) begin
            u_h[i] = 1'b0;
            d_h[i] = 1'b0;
         end
      end else begin
         for (int i = 3; i > 0; i--) begin
            u_h[i] = u_h[i-1];
            d_h[i] = d_h[i-1];
         end
         u_h[0] = vs_uir;
         d_h[0] = vs_udr;
         u_rise = u_h[2] && !u_h[3];
         d_rise = d_h[2] && !d_h[3];
         m_pop = (m_q.size() != 0) && cmd_ready;
         m_entry = {(u_rise ? ir_in : m_cur_ir), sr};
         m_acc = d_rise && ((m_q.size() < DEPTH) || m_pop);
         m_rej = d_rise && !m_acc;
         if (m_pop) void'(m_q.pop_front());
         if (m_acc) begin
            m_q.push_back(m_entry);
            sb_q.push_back(m_entry);
         end
         if (m_rej) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         if (u_rise) m_cur_ir = ir_in;
         m_irupd = u_h[1] && !u_h[2];
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      chk("cmd_valid", 64'(cmd_valid), 64'(m_q.size() != 0));
      chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("cur_ir", 64'(cur_ir), 64'(m_cur_ir));
      chk("ir_update", 64'(ir_update), 64'(m_irupd));
      if (cmd_valid) begin
         if (sb_q.size() == 0) begin
            chk("head_underflow", 64'(1), 64'(0));
         end else begin
            chk("head", 64'({cmd_ir, cmd_data}), 64'(sb_q[0]));
            if (cmd_ready) void'(sb_q.pop_front());
         end
      end
   end

   // cmd_ready driver: 0 / 1 / random / held by main (3)
   int rdy_mode = 0;
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rdy_mode == 0) cmd_ready = 1'b0;
         else if (rdy_mode == 1) cmd_ready = 1'b1;
         else if (rdy_mode == 2) cmd_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic udr(input logic [DR_W-1:0] d, input int hi);
      sr = d;
      step(1);
      vs_udr = 1'b1;
      step(hi);
      vs_udr = 1'b0;
      step(5);
   endtask

   task automatic uir(input logic [IR_W-1:0] ir, input int hi);
      ir_in = ir;
      step(1);
      vs_uir = 1'b1;
      step(hi);
      vs_uir = 1'b0;
      step(5);
   endtask

   task automatic both(input logic [IR_W-1:0] ir,
                       input logic [DR_W-1:0] d);
      ir_in = ir;
      sr = d;
      step(1);
      vs_uir = 1'b1;
      vs_udr = 1'b1;
      step(3);
      vs_uir = 1'b0;
      vs_udr = 1'b0;
      step(5);
   endtask

   task automatic drain();
      int i;
      rdy_mode = 1;
      i = 0;
      step(1);
      while (cmd_valid && i < 40) begin
         step(1);
         i++;
      end
      chk("drain_empty", 64'(cmd_valid), 64'(0));
      rdy_mode = 0;
      step(2);
   endtask

   task automatic clr_ovf();
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
   endtask

   logic [63:0] rnd;

   initial begin
      step(3);
      reset_n = 1'b1;
      step(2);
      chk("rst_valid", 64'(cmd_valid), 64'(0));
      chk("rst_level", 64'(fifo_level), 64'(0));
      chk("rst_ovf", 64'(overflow), 64'(0));
      chk("rst_cur_ir", 64'(cur_ir), 64'(0));
      chk("rst_ir_update", 64'(ir_update), 64'(0));

      // single command
      uir(2'b01, 3);
      chk("single_cur_ir", 64'(cur_ir), 64'(1));
      udr(38'h2A_DEAD_BEEF, 3);
      chk("single_valid", 64'(cmd_valid), 64'(1));
      chk("single_ir", 64'(cmd_ir), 64'(1));
      chk("single_data", 64'(cmd_data), 64'h2A_DEAD_BEEF);
      chk("single_level", 64'(fifo_level), 64'(1));
      drain();

      // ordering and pointer wrap
      for (int rep = 0; rep < 3; rep++) begin
         for (int v = 1; v <= 4; v++) udr(DR_W'(v), 3);
         chk("order_level", 64'(fifo_level), 64'(4));
         chk("order_ovf", 64'(overflow), 64'(0));
         drain();
      end

      // overflow
      for (int v = 1; v <= 5; v++) udr(DR_W'(v), 3);
      chk("ovf_set", 64'(overflow), 64'(1));
      chk("ovf_level", 64'(fifo_level), 64'(4));
      chk("ovf_head", 64'(cmd_data), 64'(1));
      clr_ovf();
      chk("ovf_clr", 64'(overflow), 64'(0));
      sr = DR_W'(6);
      step(1);
      vs_udr = 1'b1;
      step(2);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      vs_udr = 1'b0;
      step(5);
      chk("ovf_set_wins", 64'(overflow), 64'(1));
      drain();
      clr_ovf();
      chk("ovf_clr2", 64'(overflow), 64'(0));

      // full with simultaneous pop
      for (int v = 1; v <= 4; v++) udr(DR_W'(v + 10), 3);
      rdy_mode = 3;
      cmd_ready = 1'b0;
      sr = DR_W'(99);
      step(1);
      vs_udr = 1'b1;
      step(2);
      cmd_ready = 1'b1;
      step(1);
      cmd_ready = 1'b0;
      vs_udr = 1'b0;
      step(5);
      chk("fullpop_level", 64'(fifo_level), 64'(4));
      chk("fullpop_ovf", 64'(overflow), 64'(0));
      chk("fullpop_head", 64'(cmd_data), 64'(12));
      drain();

      // simultaneous UIR/UDR
      uir(2'b00, 3);
      both(2'b10, 38'h123);
      chk("simul_cur_ir", 64'(cur_ir), 64'(2));
      chk("simul_cmd_ir", 64'(cmd_ir), 64'(2));
      drain();

      // reset mid-operation with vs_udr held high
      udr(DR_W'(7), 3);
      udr(DR_W'(8), 3);
      chk("mid_level", 64'(fifo_level), 64'(2));
      sr = DR_W'(9);
      vs_udr = 1'b1;
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      chk("mid_rst_valid", 64'(cmd_valid), 64'(0));
      chk("mid_rst_level", 64'(fifo_level), 64'(0));
      step(2);
      chk("mid_pre_push", 64'(cmd_valid), 64'(0));
      step(1);
      chk("mid_push_valid", 64'(cmd_valid), 64'(1));
      chk("mid_push_data", 64'(cmd_data), 64'(9));
      vs_udr = 1'b0;
      step(5);
      chk("mid_one_only", 64'(fifo_level), 64'(1));
      drain();

      // random traffic
      rdy_mode = 2;
      repeat (60) begin
         rnd = {$urandom(), $urandom()};
         case ($urandom_range(0, 3))
            0: udr(rnd[DR_W-1:0], int'($urandom_range(2, 4)));
            1: uir(rnd[IR_W-1:0], int'($urandom_range(2, 4)));
            2: both(rnd[DR_W+1:DR_W], rnd[DR_W-1:0]);
            default: begin
               clr_ovf();
               step(int'($urandom_range(1, 3)));
            end
         endcase
      end
      drain();
      chk("sb_empty", 64'(sb_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
